buf_access_arbiter: RTL and testbench

// - Owns the shared page buffer between host port and flash-controller (NFC) port.
// - Grants exactly one owner per page transfer and drives the buffer's sel/we/re strobes.
// - Counts words to page depth; tracks page-content coherence so data is consumed once.
// - Sits between host/NFC requesters and the page buffer, issuing done pulses to both sides.

---
 rtl/nfc_buf_pkg.sv | 48 ++++
 rtl/buf_word_counter.sv | 29 ++
 rtl/buf_access_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_buf_access_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nfc_buf_pkg.sv
// Shared types and constants for the page-buffer access arbiter.
// - arb_state_e : ownership states of the shared page buffer
// - page_tag_e  : what the buffer currently holds (EMPTY / PROG_DATA / READ_DATA)
// - REQ_*       : request-vector indices; a higher index wins arbitration
// - tag_after   : buffer content left behind by a completed transfer
// - req_state   : state entered when a given request is granted
package nfc_buf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOST_WR = 3'd1,
        ST_NFC_RD  = 3'd2,
        ST_NFC_WR  = 3'd3,
        ST_HOST_RD = 3'd4
    } arb_state_e;

    typedef enum logic [1:0] {
        TAG_EMPTY     = 2'd0,
        TAG_PROG_DATA = 2'd1,
        TAG_READ_DATA = 2'd2
    } page_tag_e;

    // Priority order: nfc_rd > host_rd > nfc_wr > host_wr.
    localparam int NUM_REQ     = 4;
    localparam int REQ_HOST_WR = 0;
    localparam int REQ_NFC_WR  = 1;
    localparam int REQ_HOST_RD = 2;
    localparam int REQ_NFC_RD  = 3;

    function automatic page_tag_e tag_after(input arb_state_e st);
        case (st)
            ST_HOST_WR: return TAG_PROG_DATA;
            ST_NFC_WR:  return TAG_READ_DATA;
            default:    return TAG_EMPTY;
        endcase
    endfunction

    function automatic arb_state_e req_state(input int idx);
        case (idx)
            REQ_HOST_WR: return ST_HOST_WR;
            REQ_NFC_WR:  return ST_NFC_WR;
            REQ_HOST_RD: return ST_HOST_RD;
            REQ_NFC_RD:  return ST_NFC_RD;
            default:     return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/buf_word_counter.sv
// Word counter for one page transfer.
// Ports: clk, rst (sync, active-high), clr (return to zero), inc (count one
// beat), last (current count is the final word of the page).
module buf_word_counter
    import nfc_buf_pkg::*;
#(
    parameter int Depth = 2048,
    parameter int Width = $clog2(Depth)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic last
);

    logic [Width-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

    assign last = (count == Width'(Depth - 1));

endmodule

// File: rtl/buf_access_arbiter.sv
// Arbiter for the page buffer shared between the host port and the flash
// controller (NFC) port. One owner per page transfer; the page tag tracks the
// buffer content so each page is produced once and consumed once.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   host_wr_req/host_rd_req      host page write / read requests (level)
//   nfc_wr_req/nfc_rd_req        NFC page write / read requests (level)
//   host_valid/nfc_valid         beat strobes from the current owner
//   host_gnt/nfc_gnt             ownership indication
//   buf_sel/buf_we/buf_re        host-side buffer controls
//   cntrl_sel/cntrl_we/cntrl_re  controller-side buffer controls
//   host_done/nfc_done           one-cycle transfer-complete pulses
//   page_tag                     buffer content (page_tag_e encoding)
//   timeout_err                  one-cycle pulse when a stalled transfer aborts
// Optional feature: define BUF_ARB_TIMEOUT_EN to abort a transfer that sees no
// owner beat for TimeoutCycles consecutive cycles.
module buf_access_arbiter
    import nfc_buf_pkg::*;
#(
    parameter int PageDepth     = 2048,
    parameter int CntWidth      = $clog2(PageDepth),
    parameter int TimeoutCycles = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       host_wr_req,
    input  logic       host_rd_req,
    input  logic       nfc_wr_req,
    input  logic       nfc_rd_req,
    input  logic       host_valid,
    input  logic       nfc_valid,
    output logic       host_gnt,
    output logic       nfc_gnt,
    output logic       buf_sel,
    output logic       buf_we,
    output logic       buf_re,
    output logic       cntrl_sel,
    output logic       cntrl_we,
    output logic       cntrl_re,
    output logic       host_done,
    output logic       nfc_done,
    output logic [1:0] page_tag,
    output logic       timeout_err
);

    arb_state_e           state;
    arb_state_e           next_state;
    page_tag_e            tag_q;
    logic [NUM_REQ-1:0]   elig;
    logic                 host_owner;
    logic                 nfc_owner;
    logic                 beat;
    logic                 last;
    logic                 last_beat;
    logic                 abort;

    assign host_owner = (state == ST_HOST_WR) || (state == ST_HOST_RD);
    assign nfc_owner  = (state == ST_NFC_WR)  || (state == ST_NFC_RD);
    assign beat       = (host_owner && host_valid) || (nfc_owner && nfc_valid);
    assign last_beat  = beat && last;
    assign page_tag   = tag_q;

    // A request is only eligible when the buffer holds what it needs.
    assign elig[REQ_HOST_WR] = host_wr_req && (tag_q == TAG_EMPTY);
    assign elig[REQ_NFC_WR]  = nfc_wr_req  && (tag_q == TAG_EMPTY);
    assign elig[REQ_HOST_RD] = host_rd_req && (tag_q == TAG_READ_DATA);
    assign elig[REQ_NFC_RD]  = nfc_rd_req  && (tag_q == TAG_PROG_DATA);

`ifdef BUF_ARB_TIMEOUT_EN
    localparam int StallWidth = $clog2(TimeoutCycles + 1);

    logic [StallWidth-1:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst || (state == ST_IDLE) || beat) begin
            stall_cnt <= '0;
        end else begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

    // The current beat-less cycle is the TimeoutCycles-th in a row.
    assign abort = (host_owner || nfc_owner) && !beat &&
                   (stall_cnt == StallWidth'(TimeoutCycles - 1));
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TimeoutCycles != 0);
    assign abort              = 1'b0;
`endif

    buf_word_counter #(
        .Depth (PageDepth),
        .Width (CntWidth)
    ) u_word_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (last_beat || abort),
        .inc  (beat),
        .last (last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Ascending scan: the highest-index eligible request overrides the rest.
    // Leaving a transfer always passes through IDLE, so grants are never
    // back-to-back.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (elig[i]) begin
                        next_state = req_state(i);
                    end
                end
            end
            default: begin
                if (last_beat || abort) begin
                    next_state = ST_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        host_gnt  = 1'b0;
        nfc_gnt   = 1'b0;
        buf_sel   = 1'b0;
        buf_we    = 1'b0;
        buf_re    = 1'b0;
        cntrl_sel = 1'b0;
        cntrl_we  = 1'b0;
        cntrl_re  = 1'b0;
        case (state)
            ST_HOST_WR: begin
                host_gnt = 1'b1;
                buf_sel  = 1'b1;
                buf_we   = host_valid;
            end
            ST_HOST_RD: begin
                host_gnt = 1'b1;
                buf_sel  = 1'b1;
                buf_re   = host_valid;
            end
            ST_NFC_WR: begin
                nfc_gnt   = 1'b1;
                cntrl_sel = 1'b1;
                cntrl_we  = nfc_valid;
            end
            ST_NFC_RD: begin
                nfc_gnt   = 1'b1;
                cntrl_sel = 1'b1;
                cntrl_re  = nfc_valid;
            end
            default: ;
        endcase
    end

    // Tag and completion pulses; a reset or abort discards the partial page.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_q       <= TAG_EMPTY;
            host_done   <= 1'b0;
            nfc_done    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            host_done   <= last_beat && host_owner;
            nfc_done    <= last_beat && nfc_owner;
            timeout_err <= abort;
            if (last_beat) begin
                tag_q <= tag_after(state);
            end else if (abort) begin
                tag_q <= TAG_EMPTY;
            end
        end
    end

endmodule

// File: tb/tb_buf_access_arbiter.sv
// Directed bench for buf_access_arbiter (PageDepth=8, TimeoutCycles=4).
// Completion pulses are matched against a queue of expected {side, tag}
// entries pushed while the stimulus is driven.
module tb_buf_access_arbiter;

    localparam int DEPTH = 8;

    localparam logic [1:0] SIDE_HOST = 2'b10;
    localparam logic [1:0] SIDE_NFC  = 2'b01;

    localparam logic [1:0] T_EMPTY = 2'd0;
    localparam logic [1:0] T_PROG  = 2'd1;
    localparam logic [1:0] T_READ  = 2'd2;

    typedef struct {
        logic [1:0] side;
        logic [1:0] tag;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       host_wr_req, host_rd_req, nfc_wr_req, nfc_rd_req;
    logic       host_valid, nfc_valid;
    logic       host_gnt, nfc_gnt;
    logic       buf_sel, buf_we, buf_re;
    logic       cntrl_sel, cntrl_we, cntrl_re;
    logic       host_done, nfc_done;
    logic [1:0] page_tag;
    logic       timeout_err;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    int we_n = 0, re_n = 0, cwe_n = 0, cre_n = 0;
    int hd_n = 0, nd_n = 0, to_n = 0;

    buf_access_arbiter #(
        .PageDepth     (DEPTH),
        .TimeoutCycles (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .host_wr_req (host_wr_req),
        .host_rd_req (host_rd_req),
        .nfc_wr_req  (nfc_wr_req),
        .nfc_rd_req  (nfc_rd_req),
        .host_valid  (host_valid),
        .nfc_valid   (nfc_valid),
        .host_gnt    (host_gnt),
        .nfc_gnt     (nfc_gnt),
        .buf_sel     (buf_sel),
        .buf_we      (buf_we),
        .buf_re      (buf_re),
        .cntrl_sel   (cntrl_sel),
        .cntrl_we    (cntrl_we),
        .cntrl_re    (cntrl_re),
        .host_done   (host_done),
        .nfc_done    (nfc_done),
        .page_tag    (page_tag),
        .timeout_err (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [1:0] side, input logic [1:0] tag);
        exp_t e;
        e.side = side;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    // Strobe counting and scoreboard matching on the falling edge.
    always @(negedge clk) begin
        if (buf_we)      we_n++;
        if (buf_re)      re_n++;
        if (cntrl_we)    cwe_n++;
        if (cntrl_re)    cre_n++;
        if (host_done)   hd_n++;
        if (nfc_done)    nd_n++;
        if (timeout_err) to_n++;
        if (host_done || nfc_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {host_done, nfc_done}, 2'b00);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_side", {30'd0, host_done, nfc_done}, {30'd0, e.side});
                chk("done_tag", {30'd0, page_tag}, {30'd0, e.tag});
            end
        end
    end

    initial begin
        int base_a, base_b, base_c, base_d, gnt_seen;

        rst = 1'b1;
        host_wr_req = 1'b0; host_rd_req = 1'b0;
        nfc_wr_req  = 1'b0; nfc_rd_req  = 1'b0;
        host_valid  = 1'b0; nfc_valid   = 1'b0;
        repeat (3) tick();

        chk("rst_host_gnt", host_gnt, 1'b0);
        chk("rst_nfc_gnt", nfc_gnt, 1'b0);
        chk("rst_tag", page_tag, T_EMPTY);
        chk("rst_strobes", {buf_sel, buf_we, buf_re, cntrl_sel, cntrl_we, cntrl_re}, 6'd0);
        chk("rst_pulses", {host_done, nfc_done, timeout_err}, 3'd0);
        rst = 1'b0;
        tick();

        // Host programs a page; request dropped right after grant.
        host_wr_req = 1'b1;
        tick();
        chk("hw_gnt", {host_gnt, buf_sel, nfc_gnt, cntrl_sel}, 4'b1100);
        host_wr_req = 1'b0;
        base_a = we_n; base_b = hd_n;
        push_exp(SIDE_HOST, T_PROG);
        host_valid = 1'b1;
        repeat (DEPTH) tick();
        host_valid = 1'b0;
        chk("hw_gnt_after_last", host_gnt, 1'b0);
        tick();
        chk("hw_we_count", we_n - base_a, DEPTH);
        chk("hw_done_count", hd_n - base_b, 1);
        chk("hw_tag", page_tag, T_PROG);

        // NFC consumes the program page.
        nfc_rd_req = 1'b1;
        tick();
        chk("nr_gnt", {host_gnt, nfc_gnt, cntrl_sel}, 3'b011);
        nfc_rd_req = 1'b0;
        base_a = cre_n; base_b = nd_n; base_c = we_n + re_n;
        push_exp(SIDE_NFC, T_EMPTY);
        nfc_valid = 1'b1;
        repeat (DEPTH) tick();
        nfc_valid = 1'b0;
        tick();
        chk("nr_re_count", cre_n - base_a, DEPTH);
        chk("nr_done_count", nd_n - base_b, 1);
        chk("nr_host_strobes", we_n + re_n - base_c, 0);
        chk("nr_tag", page_tag, T_EMPTY);

        // Simultaneous writes at EMPTY: NFC wins, host write stays pending.
        host_wr_req = 1'b1;
        nfc_wr_req  = 1'b1;
        tick();
        chk("prio_gnt", {host_gnt, nfc_gnt}, 2'b01);
        nfc_wr_req = 1'b0;
        base_a = cwe_n;
        push_exp(SIDE_NFC, T_READ);
        nfc_valid = 1'b1;
        repeat (DEPTH) tick();
        nfc_valid = 1'b0;
        chk("nw_gnt_after_last", {host_gnt, nfc_gnt}, 2'b00);
        repeat (3) tick();
        chk("nw_we_count", cwe_n - base_a, DEPTH);
        chk("nw_tag", page_tag, T_READ);
        chk("pending_host_wr", host_gnt, 1'b0);
        host_rd_req = 1'b1;
        tick();
        chk("hr_gnt", {host_gnt, buf_sel, nfc_gnt}, 3'b110);
        host_rd_req = 1'b0;
        host_wr_req = 1'b0;
        base_a = re_n; base_b = hd_n;
        push_exp(SIDE_HOST, T_EMPTY);
        host_valid = 1'b1;
        repeat (DEPTH) tick();
        host_valid = 1'b0;
        tick();
        chk("hr_re_count", re_n - base_a, DEPTH);
        chk("hr_done_count", hd_n - base_b, 1);
        chk("hr_tag", page_tag, T_EMPTY);

        // Read request against an empty buffer is never granted.
        base_a = we_n + re_n + cwe_n + cre_n;
        gnt_seen = 0;
        host_rd_req = 1'b1;
        host_valid  = 1'b1;
        nfc_valid   = 1'b1;
        repeat (20) begin
            tick();
            if (host_gnt || nfc_gnt || buf_sel || cntrl_sel) gnt_seen++;
        end
        host_rd_req = 1'b0;
        host_valid  = 1'b0;
        nfc_valid   = 1'b0;
        chk("inel_no_gnt", gnt_seen, 0);
        chk("inel_no_strobe", we_n + re_n + cwe_n + cre_n - base_a, 0);
        tick();

        // Reset in the middle of a host write discards the page.
        host_wr_req = 1'b1;
        tick();
        chk("rw_gnt", host_gnt, 1'b1);
        host_wr_req = 1'b0;
        base_b = hd_n;
        host_valid = 1'b1;
        repeat (3) tick();
        host_valid = 1'b0;
        rst = 1'b1;
        tick();
        chk("rw_rst_gnt", host_gnt, 1'b0);
        chk("rw_rst_tag", page_tag, T_EMPTY);
        rst = 1'b0;
        repeat (3) tick();
        chk("rw_no_done", hd_n - base_b, 0);

        // Fresh write after reset must take a full page.
        host_wr_req = 1'b1;
        tick();
        host_wr_req = 1'b0;
        host_valid = 1'b1;
        repeat (DEPTH - 1) tick();
        chk("fw_still_gnt", host_gnt, 1'b1);
        chk("fw_no_early_done", hd_n - base_b, 0);
        push_exp(SIDE_HOST, T_PROG);
        tick();
        host_valid = 1'b0;
        tick();
        chk("fw_done_count", hd_n - base_b, 1);
        chk("fw_tag", page_tag, T_PROG);

        // NFC read granted, then stalls for four cycles.
        base_b = nd_n; base_d = to_n;
        nfc_rd_req = 1'b1;
        tick();
        chk("to_gnt", nfc_gnt, 1'b1);
        nfc_rd_req = 1'b0;
        repeat (4) tick();
`ifdef BUF_ARB_TIMEOUT_EN
        chk("to_gnt_dropped", nfc_gnt, 1'b0);
        chk("to_err_pulse", timeout_err, 1'b1);
        chk("to_tag", page_tag, T_EMPTY);
        tick();
        chk("to_err_once", to_n - base_d, 1);
        chk("to_no_done", nd_n - base_b, 0);
`else
        chk("to_still_gnt", nfc_gnt, 1'b1);
        chk("to_no_err", timeout_err, 1'b0);
        push_exp(SIDE_NFC, T_EMPTY);
        nfc_valid = 1'b1;
        repeat (DEPTH) tick();
        nfc_valid = 1'b0;
        tick();
        chk("to_done_count", nd_n - base_b, 1);
        chk("to_err_count", to_n - base_d, 0);
        chk("to_tag", page_tag, T_EMPTY);
`endif
        repeat (2) tick();
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
